// File: rtl/sonar_ping_ctrl_if.sv
// -----------------------------------------------------------------------------
// sonar_ping_ctrl_if
// Groups the control, tone-feedback, echo and result signals of one sonar
// ping controller.
//   start, abort  : host requests (host -> controller)
//   wave          : tone generator output fed back (generator -> controller)
//   echo          : receiver comparator output, asynchronous (rx -> controller)
//   tone_en       : tone generator enable / active-low generator reset
//   busy, done    : ping in progress / one-cycle result-valid pulse
//   echo_hit, timeout, tof : result of the last ping
// Modports: slave = the controller, master = the host/bench side.
// -----------------------------------------------------------------------------
interface sonar_ping_ctrl_if #(
   parameter int TOF_W = 24
);
   logic             start;
   logic             abort;
   logic             wave;
   logic             echo;
   logic             tone_en;
   logic             busy;
   logic             done;
   logic             echo_hit;
   logic             timeout;
   logic [TOF_W-1:0] tof;

   modport slave (
      input  start, abort, wave, echo,
      output tone_en, busy, done, echo_hit, timeout, tof
   );

   modport master (
      output start, abort, wave, echo,
      input  tone_en, busy, done, echo_hit, timeout, tof
   );
endinterface

// File: rtl/sonar_ping_ctrl.sv
// -----------------------------------------------------------------------------
// sonar_ping_ctrl
// Sequences one sonar ping: enables the tone generator for BURST_CYCLES tone
// periods (counted on falling edges of the fed-back wave), blanks the receiver
// for BLANK_CLKS cycles while the transducer rings down, then measures the
// clock-cycle time of flight from burst start to the first synchronized echo
// rise, or reports a timeout at MAX_TOF_CLKS.
// Ports:
//   clk  : clock, all logic on the rising edge
//   rstn : asynchronous active-low reset
//   bus  : sonar_ping_ctrl_if.slave (start/abort/wave/echo in,
//          tone_en/busy/done/echo_hit/timeout/tof out)
// -----------------------------------------------------------------------------
module sonar_ping_ctrl #(
   parameter int BURST_CYCLES = 8,
   parameter int BLANK_CLKS   = 1000,
   parameter int MAX_TOF_CLKS = 1000000,
   parameter int TOF_W        = 24
) (
   input  logic                  clk,
   input  logic                  rstn,
   sonar_ping_ctrl_if.slave      bus
);

   // One counter is shared: it counts wave falls in BURST and cycles in BLANK.
   localparam int CNT_MAX = (BURST_CYCLES > BLANK_CLKS) ? BURST_CYCLES : BLANK_CLKS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] LAST_FALL  = CNT_W'(BURST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LAST_BLANK = CNT_W'(BLANK_CLKS - 1);
   localparam logic [TOF_W-1:0] DEADLINE   = TOF_W'(MAX_TOF_CLKS - 1);

   typedef enum logic [2:0] {
      IDLE,
      BURST,
      BLANK,
      LISTEN,
      DONE
   } state_t;

   state_t           r_state;
   logic [TOF_W-1:0] r_t;
   logic [CNT_W-1:0] r_cnt;
   logic             r_wave_d;
   logic             r_s1, r_s2, r_s3;
   logic             r_tone_en;
   logic             r_busy;
   logic             r_done;
   logic             r_echo_hit;
   logic             r_timeout;
   logic [TOF_W-1:0] r_tof;

   logic             w_fall;
   logic             w_rise;

   assign w_fall = r_wave_d & ~bus.wave;
   assign w_rise = r_s2 & ~r_s3;

   // NOTE: every register in this block is updated with <= so that all of them
   // see the pre-edge values of each other; blocking = here would reorder the
   // synchronizer chain into a single flop.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= IDLE;
         r_t        <= '0;
         r_cnt      <= '0;
         r_wave_d   <= 1'b0;
         r_s1       <= 1'b0;
         r_s2       <= 1'b0;
         r_s3       <= 1'b0;
         r_tone_en  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_echo_hit <= 1'b0;
         r_timeout  <= 1'b0;
         r_tof      <= '0;
      end else begin
         // Edge detectors run in every state; only LISTEN acts on the echo rise.
         r_wave_d <= bus.wave;
         r_s1     <= bus.echo;
         r_s2     <= r_s1;
         r_s3     <= r_s2;
         r_done   <= 1'b0;

         if (bus.abort) begin
            r_state    <= IDLE;
            r_tone_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_t        <= '0;
            r_cnt      <= '0;
            r_echo_hit <= 1'b0;
            r_timeout  <= 1'b0;
            r_tof      <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_t   <= '0;
                  r_cnt <= '0;
                  if (bus.start) begin
                     r_state    <= BURST;
                     r_tone_en  <= 1'b1;
                     r_busy     <= 1'b1;
                     r_echo_hit <= 1'b0;
                     r_timeout  <= 1'b0;
                     r_tof      <= '0;
                  end
               end

               BURST: begin
                  r_t <= r_t + 1'b1;
                  if (w_fall) begin
                     if (r_cnt == LAST_FALL) begin
                        r_state   <= BLANK;
                        r_tone_en <= 1'b0;
                        r_cnt     <= '0;
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
               end

               BLANK: begin
                  r_t <= r_t + 1'b1;
                  if (r_cnt == LAST_BLANK) begin
                     r_state <= LISTEN;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end

               LISTEN: begin
                  // Echo is tested first so it wins over a coincident deadline.
                  // t is not advanced on the exit edge, so it never exceeds
                  // MAX_TOF_CLKS-1 and cannot wrap even when 2^TOF_W equals it.
                  if (w_rise) begin
                     r_state    <= DONE;
                     r_tof      <= r_t;
                     r_echo_hit <= 1'b1;
                     r_done     <= 1'b1;
                  end else if (r_t == DEADLINE) begin
                     r_state   <= DONE;
                     r_tof     <= '0;
                     r_timeout <= 1'b1;
                     r_done    <= 1'b1;
                  end else begin
                     r_t <= r_t + 1'b1;
                  end
               end

               DONE: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end

               default: begin
                  r_state   <= IDLE;
                  r_tone_en <= 1'b0;
                  r_busy    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.tone_en  = r_tone_en;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.echo_hit = r_echo_hit;
   assign bus.timeout  = r_timeout;
   assign bus.tof      = r_tof;

endmodule

// File: doc/sonar_ping_ctrl.md
# sonar_ping_ctrl

Sequences one sonar ping: gates the tone generator for a fixed number of tone periods, blanks the receiver while the transducer rings down, and then measures the time of flight to the first echo edge. It sits between the host/control logic, which issues `start`, and the tone generator. Its `tone_en` output drives the tone generator's active-low reset directly, and the tone generator's `wave` output feeds back into this block. The result is a clock-cycle time-of-flight value plus a hit/timeout status.

## Interface
Parameters:
- `BURST_CYCLES`, default 8: number of complete tone periods per ping; must be ≥ 1.
- `BLANK_CLKS`, default 1000: receiver blanking time after the burst, in clk cycles; must be ≥ 1.
- `MAX_TOF_CLKS`, default 1000000: listen deadline, in clk cycles measured from burst start; must be > burst length + `BLANK_CLKS`.
- `TOF_W`, default 24: width of the time-of-flight counter; requires 2^`TOF_W` ≥ `MAX_TOF_CLKS`.

Ports:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rstn`  in  1: reset, asynchronous and active-low.
- `start`  in  1: pulse requesting a ping; sampled only in IDLE.
- `abort`  in  1: returns the block to IDLE from any state; no `done` is issued.
- `wave`  in  1: tone output fed back from the tone generator (synchronous to `clk`).
- `echo`  in  1: receiver comparator output; asynchronous.
- `tone_en`  out  1: tone generator enable; connects to the generator's active-low reset.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when a result becomes valid.
- `echo_hit`  out  1: last ping detected an echo.
- `timeout`  out  1: last ping reached `MAX_TOF_CLKS` without an echo.
- `tof`  out  `TOF_W`: cycle count from burst start to echo detection; 0 on timeout.

## Operation
- States: IDLE, BURST, BLANK, LISTEN, DONE.
- IDLE:
  - `start`=1 → BURST.
  - Time counter `t` cleared to 0.
  - Falling-edge counter cleared.
  - `echo_hit`, `timeout` and `tof` cleared at the same edge.
- BURST:
  - `tone_en`=1.
  - Falling edges of `wave` are counted (registered `wave_d`; fall = `wave_d` & ~`wave`).
  - On the `BURST_CYCLES`-th fall → BLANK, with `tone_en`=0 from that edge.
- BLANK:
  - Lasts exactly `BLANK_CLKS` cycles, then → LISTEN.
  - Echo edges are ignored.
- LISTEN:
  - Echo rise detected → DONE, with `tof`<=`t` and `echo_hit`<=1.
  - Else if `t` == `MAX_TOF_CLKS`-1 → DONE, with `timeout`<=1 and `tof`<=0.
  - If echo rise and the deadline occur in the same cycle, echo wins.
- DONE: `done`=1 for one cycle, then → IDLE. Results hold until the next accepted `start`.
- Echo synchronizer:
  - Chain `s1`<=`echo`, `s2`<=`s1`, `s3`<=`s2`; rise = `s2` & ~`s3`.
  - The chain runs in all states. Only a rise seen while in LISTEN counts.
  - If `echo` is already high on LISTEN entry, it must fall and rise again to be detected.
- `t` is reset to 0 on entry to BURST. It increments by 1 every cycle in BURST, BLANK and LISTEN. It never wraps; the parameter constraint guarantees this.
- `tof` includes the 2-cycle synchronizer latency, uncompensated. An echo first sampled high by `s1` at the edge where `t`=k yields `tof`=k+2.
- `abort` has priority over every transition. It forces IDLE at the next edge with `tone_en`=0 and `done`=0, and clears the results.
- `start` while busy is ignored.
- If `wave` never toggles, BURST does not terminate by itself; `abort` is the recovery path.

## Timing
- Reset values: state IDLE, `tone_en`=0, `busy`=0, `done`=0, `echo_hit`=0, `timeout`=0, `tof`=0, all counters 0, synchronizer flops 0.
- `start` sampled high at edge E → `tone_en`=1 and `busy`=1 after E.
- Last `wave` fall sampled at edge F → `tone_en`=0 after F.
- BLANK occupies `BLANK_CLKS` cycles; LISTEN begins after that.
- Echo rise combinational in cycle C → `done`, `tof` and `echo_hit` valid after the edge ending C; `busy` drops one cycle later.
- A `start` in the DONE cycle is ignored; the earliest re-start is the first IDLE cycle.
- Reset asserted mid-ping → immediate return to reset values, including `tone_en`=0.

## Test plan
- Setup for the scenarios below: `BURST_CYCLES`=2, `BLANK_CLKS`=10, `MAX_TOF_CLKS`=100; `wave` modeled as 4 clk high / 4 clk low after `tone_en`.
- Basic ping: `start` pulse; bench raises `echo` so that `s1` captures it at `t`=40 → `done` pulse, `tof`=42, `echo_hit`=1, `timeout`=0, `tone_en` high for exactly 2 `wave` falls.
- Echo during BLANK: `echo` rises at `t`=18 (inside BLANK) and stays high → no detection; run ends with `timeout`=1, `tof`=0, `done` at `t`=99.
- Timeout with no echo → `done` once, `timeout`=1, `echo_hit`=0, `busy` low one cycle after `done`.
- Abort: `abort` during BLANK → IDLE next edge, `done` never asserted, `tof`=0. A subsequent `start` performs a full normal ping.
- Boundary cases:
  - Echo rise coinciding with the deadline cycle → `echo_hit`=1, `tof`=99, `timeout`=0.
  - `start` held high through a whole ping → back-to-back pings, each with one `done`.
- Async reset: `rstn` deasserted while in BURST → `tone_en`=0 immediately and all outputs at their reset values.
